stack_packetizer: RTL and testbench

STACK_PACKETIZER -- requirements
Module: stack_packetizer

---
 rtl/stack_packetizer_pkg.sv | 27 ++
 rtl/stack_packetizer.sv | 152 +++++++++++++++
 tb/tb_stack_packetizer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_packetizer_pkg.sv
// Shared definitions for the stack diagnosis path: flit type codes, event class
// and header geometry used by the stack stage and its packetizer.
package stack_packetizer_pkg;

    typedef enum logic [2:0] {
        FT_NONE   = 3'd0,
        FT_FIRST  = 3'd1,
        FT_MIDDLE = 3'd2,
        FT_LAST   = 3'd3,
        FT_SINGLE = 3'd4
    } flit_type_e;

    localparam logic [3:0] EVT_CLASS_STACK = 4'h3;
    localparam int         HDR_FLITS       = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR_DEST = 3'd1,
        ST_HDR_SRC  = 3'd2,
        ST_HDR_TYPE = 3'd3,
        ST_TS_LO    = 3'd4,
        ST_TS_HI    = 3'd5,
        ST_ARG_LO   = 3'd6,
        ST_ARG_HI   = 3'd7
    } pkt_state_e;

endpackage

// File: rtl/stack_packetizer.sv
// Packs stack argument words into 16-bit debug NoC flits: five header flits
// (dest, src, type, timestamp lo/hi) followed by two flits per argument word.
module stack_packetizer
    import stack_packetizer_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter logic [15:0] DEST       = 16'h0000,
    parameter int          MAX_ARGS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           id,
    input  logic [31:0]           timestamp,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [2:0]            in_type,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [15:0]           debug_out,
    output logic                  debug_out_last,
    output logic                  debug_out_valid,
    input  logic                  debug_out_ready,
    output logic                  err
);

    // Handshake: a word moves on in_valid && in_ready, a flit on
    // debug_out_valid && debug_out_ready; upstream holds its word while stalled.

    pkt_state_e  state, state_next;
    logic [7:0]  seq, seq_next;
    logic [5:0]  arg_cnt, arg_cnt_next;
    logic        cont, cont_next;
    logic [31:0] ts_reg, ts_next;
    logic        err_next;

    logic first_word;
    logic word_hs;
    logic end_word;
    logic bad_type;

    assign first_word = !cont && (arg_cnt == 6'd0);
    assign word_hs    = in_valid && debug_out_ready;
    // FIRST seen mid-event counts as MIDDLE; SINGLE/NONE mid-event close it.
    assign end_word   = (in_type == FT_LAST) || (in_type == FT_SINGLE) || (in_type == FT_NONE);
    assign bad_type   = (in_type == FT_FIRST) || (in_type == FT_SINGLE) || (in_type == FT_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            seq     <= 8'd0;
            arg_cnt <= 6'd0;
            cont    <= 1'b0;
            ts_reg  <= 32'd0;
            err     <= 1'b0;
        end else begin
            state   <= state_next;
            seq     <= seq_next;
            arg_cnt <= arg_cnt_next;
            cont    <= cont_next;
            ts_reg  <= ts_next;
            err     <= err_next;
        end
    end

    always_comb begin
        state_next      = state;
        seq_next        = seq;
        arg_cnt_next    = arg_cnt;
        cont_next       = cont;
        ts_next         = ts_reg;
        err_next        = err;
        in_ready        = 1'b0;
        debug_out       = 16'h0000;
        debug_out_last  = 1'b0;
        debug_out_valid = 1'b0;

        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    ts_next      = timestamp;
                    arg_cnt_next = 6'd0;
                    cont_next    = 1'b0;
                    state_next   = ST_HDR_DEST;
                end
            end
            ST_HDR_DEST: begin
                debug_out_valid = 1'b1;
                debug_out       = DEST;
                if (debug_out_ready) state_next = ST_HDR_SRC;
            end
            ST_HDR_SRC: begin
                debug_out_valid = 1'b1;
                debug_out       = id;
                if (debug_out_ready) state_next = ST_HDR_TYPE;
            end
            ST_HDR_TYPE: begin
                debug_out_valid = 1'b1;
                debug_out       = {EVT_CLASS_STACK, cont, 3'b000, seq};
                if (debug_out_ready) state_next = ST_TS_LO;
            end
            ST_TS_LO: begin
                debug_out_valid = 1'b1;
                debug_out       = ts_reg[15:0];
                if (debug_out_ready) state_next = ST_TS_HI;
            end
            ST_TS_HI: begin
                debug_out_valid = 1'b1;
                debug_out       = ts_reg[31:16];
                // An argument-less event is closed here and its NONE word dropped.
                if (in_valid && (in_type == FT_NONE)) begin
                    debug_out_last = 1'b1;
                    in_ready       = debug_out_ready;
                    if (debug_out_ready) state_next = ST_IDLE;
                end else if (debug_out_ready) begin
                    state_next = ST_ARG_LO;
                end
            end
            ST_ARG_LO: begin
                debug_out_valid = in_valid;
                debug_out       = in_data[15:0];
                if (word_hs) begin
                    if (!first_word && bad_type) err_next = 1'b1;
                    state_next = ST_ARG_HI;
                end
            end
            ST_ARG_HI: begin
                debug_out_valid = in_valid;
                debug_out       = in_data[31:16];
                in_ready        = debug_out_ready;
                if (end_word) begin
                    debug_out_last = in_valid;
                    if (word_hs) begin
                        seq_next   = seq + 8'd1;
                        state_next = ST_IDLE;
                    end
                end else if (arg_cnt == 6'(MAX_ARGS - 1)) begin
                    // Packet full: close it and reopen a continuation of the same event.
                    debug_out_last = in_valid;
                    if (word_hs) begin
                        cont_next    = 1'b1;
                        arg_cnt_next = 6'd0;
                        state_next   = ST_HDR_DEST;
                    end
                end else if (word_hs) begin
                    arg_cnt_next = arg_cnt + 6'd1;
                    state_next   = ST_ARG_LO;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_packetizer.sv
// Directed bench for stack_packetizer: drives argument words from a source
// queue, records every accepted flit and compares against hand-built flit lists.
module tb_stack_packetizer;
    import stack_packetizer_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] id;
    logic [31:0] timestamp;
    logic [31:0] in_data;
    logic [2:0]  in_type;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] debug_out;
    logic        debug_out_last;
    logic        debug_out_valid;
    logic        debug_out_ready;
    logic        err;

    stack_packetizer #(.DATA_WIDTH(32), .DEST(16'h0000), .MAX_ARGS(8)) dut (
        .clk(clk),
        .rst(rst),
        .id(id),
        .timestamp(timestamp),
        .in_data(in_data),
        .in_type(in_type),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .debug_out(debug_out),
        .debug_out_last(debug_out_last),
        .debug_out_valid(debug_out_valid),
        .debug_out_ready(debug_out_ready),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [34:0] src_q[$];
    logic [16:0] cap_q[$];
    logic [16:0] exp_q[$];
    logic        take_word = 1'b0;
    logic        rnd_ready = 1'b0;
    int          in_ready_cnt = 0;
    int          bad_ready_cnt = 0;

    task automatic push_word(input logic [2:0] t, input logic [31:0] d);
        src_q.push_back({t, d});
    endtask

    task automatic exp_hdr(input logic [15:0] src, input logic [15:0] typ, input logic [31:0] ts);
        exp_q.push_back({1'b0, 16'h0000});
        exp_q.push_back({1'b0, src});
        exp_q.push_back({1'b0, typ});
        exp_q.push_back({1'b0, ts[15:0]});
        exp_q.push_back({1'b0, ts[31:16]});
    endtask

    task automatic exp_arg(input logic [31:0] d, input logic last);
        exp_q.push_back({1'b0, d[15:0]});
        exp_q.push_back({last, d[31:16]});
    endtask

    // One cycle: present inputs after the edge, observe outputs on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (take_word && src_q.size() > 0) void'(src_q.pop_front());
        take_word = 1'b0;
        if (src_q.size() > 0) begin
            in_valid = 1'b1;
            in_type  = src_q[0][34:32];
            in_data  = src_q[0][31:0];
        end else begin
            in_valid = 1'b0;
            in_type  = 3'd0;
            in_data  = 32'd0;
        end
        debug_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (debug_out_valid && debug_out_ready) cap_q.push_back({debug_out_last, debug_out});
        if (in_valid && in_ready) begin
            take_word = 1'b1;
            in_ready_cnt++;
        end
        if (in_ready && !(debug_out_valid && debug_out_ready)) bad_ready_cnt++;
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int cyc = 0;
        while (cap_q.size() < n && cyc < budget) begin
            step();
            cyc++;
        end
        n_checks++;
        if (cap_q.size() < n) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d flits, required %0d", name, cap_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        id = 16'h0000;
        timestamp = 32'h0;
        in_data = 32'h0;
        in_type = 3'd0;
        in_valid = 1'b0;
        debug_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 5;
        if (debug_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", debug_out_valid); end
        if (debug_out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b required 0", debug_out_last); end
        if (debug_out !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h required 0000", debug_out); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
        rst = 1'b0;
        step();
        n_checks++;
        if (cap_q.size() != 0) begin n_fail++; $display("FAIL idle_no_flit: got %0d flits required 0", cap_q.size()); end
    endtask

    task automatic test_single();
        cap_q.delete(); exp_q.delete();
        id = 16'h0005;
        timestamp = 32'h0001_2345;
        push_word(FT_SINGLE, 32'hDEAD_BEEF);
        exp_hdr(16'h0005, 16'h3000, 32'h0001_2345);
        exp_arg(32'hDEAD_BEEF, 1'b1);
        run_until(1, 20, "single_start");
        timestamp = 32'hFFFF_FFFF;
        run_until(HDR_FLITS + 2, 30, "single");
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL single_flit%0d: got %h required %h", i, (i < cap_q.size()) ? cap_q[i] : 17'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_none();
        cap_q.delete(); exp_q.delete();
        timestamp = 32'h00AB_CDEF;
        in_ready_cnt = 0;
        push_word(FT_NONE, 32'h1234_5678);
        exp_hdr(16'h0005, 16'h3001, 32'h00AB_CDEF);
        exp_q[4][16] = 1'b1;
        run_until(HDR_FLITS, 30, "none");
        repeat (4) step();
        n_checks += 2;
        if (cap_q.size() != HDR_FLITS) begin n_fail++; $display("FAIL none_count: got %0d flits required 5", cap_q.size()); end
        if (in_ready_cnt != 1) begin n_fail++; $display("FAIL none_in_ready: got %0d pulses required 1", in_ready_cnt); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL none_flit%0d: got %h required %h", i, (i < cap_q.size()) ? cap_q[i] : 17'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_continuation();
        logic [31:0] d;
        cap_q.delete(); exp_q.delete();
        id = 16'h0042;
        timestamp = 32'h0000_0100;
        exp_hdr(16'h0042, 16'h3001, 32'h0000_0100);
        for (int i = 0; i < 11; i++) begin
            d = {16'(16'hA000 + i), 16'(16'hB000 + i)};
            push_word((i == 0) ? FT_FIRST : (i == 10) ? FT_LAST : FT_MIDDLE, d);
            if (i == 8) exp_hdr(16'h0042, 16'h3801, 32'h0000_0100);
            exp_arg(d, (i == 7) || (i == 10));
        end
        run_until(32, 100, "continuation");
        n_checks += 2;
        if (cap_q.size() != 32) begin n_fail++; $display("FAIL cont_count: got %0d flits required 32", cap_q.size()); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL cont_err: got %b required 0", err); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL cont_flit%0d: got %h required %h", i, (i < cap_q.size()) ? cap_q[i] : 17'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_random_ready();
        cap_q.delete(); exp_q.delete();
        id = 16'h0007;
        timestamp = 32'h5A5A_0F0F;
        in_ready_cnt = 0;
        bad_ready_cnt = 0;
        rnd_ready = 1'b1;
        push_word(FT_FIRST, 32'h1111_2222);
        push_word(FT_MIDDLE, 32'h3333_4444);
        push_word(FT_LAST, 32'h5555_6666);
        exp_hdr(16'h0007, 16'h3002, 32'h5A5A_0F0F);
        exp_arg(32'h1111_2222, 1'b0);
        exp_arg(32'h3333_4444, 1'b0);
        exp_arg(32'h5555_6666, 1'b1);
        run_until(11, 400, "random_ready");
        rnd_ready = 1'b0;
        step();
        n_checks += 2;
        if (in_ready_cnt != 3) begin n_fail++; $display("FAIL rr_in_ready: got %0d words required 3", in_ready_cnt); end
        if (bad_ready_cnt != 0) begin n_fail++; $display("FAIL rr_stray_ready: got %0d cycles required 0", bad_ready_cnt); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rr_flit%0d: got %h required %h", i, (i < cap_q.size()) ? cap_q[i] : 17'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_protocol_error();
        cap_q.delete(); exp_q.delete();
        id = 16'h0009;
        timestamp = 32'h0000_0042;
        push_word(FT_MIDDLE, 32'hAAAA_0001);
        push_word(FT_FIRST, 32'hAAAA_0002);
        push_word(FT_LAST, 32'hAAAA_0003);
        exp_hdr(16'h0009, 16'h3003, 32'h0000_0042);
        exp_arg(32'hAAAA_0001, 1'b0);
        exp_arg(32'hAAAA_0002, 1'b0);
        exp_arg(32'hAAAA_0003, 1'b1);
        push_word(FT_SINGLE, 32'hCAFE_F00D);
        exp_hdr(16'h0009, 16'h3004, 32'h0000_0042);
        exp_arg(32'hCAFE_F00D, 1'b1);
        run_until(11, 60, "proto_err");
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b required 1", err); end
        run_until(18, 60, "proto_err_next");
        repeat (3) step();
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b required 1", err); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL err_flit%0d: got %h required %h", i, (i < cap_q.size()) ? cap_q[i] : 17'h0, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        int n_last = 0;
        cap_q.delete(); exp_q.delete();
        id = 16'h000C;
        timestamp = 32'h0000_7777;
        push_word(FT_FIRST, 32'hBEEF_0001);
        push_word(FT_MIDDLE, 32'hBEEF_0002);
        push_word(FT_LAST, 32'hBEEF_0003);
        run_until(HDR_FLITS + 1, 30, "mid_reset_reach");
        @(posedge clk);
        #1;
        n_checks += 2;
        if (debug_out !== 16'hBEEF) begin n_fail++; $display("FAIL mid_arg_hi: got %h required beef", debug_out); end
        if (cap_q.size() > 2 && cap_q[2] !== {1'b0, 16'h3005}) begin
            n_fail++;
            $display("FAIL mid_hdr_type: got %h required 03005", cap_q[2]);
        end
        rst = 1'b1;
        #1;
        n_checks += 4;
        if (debug_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b required 0", debug_out_valid); end
        if (debug_out !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_data: got %h required 0000", debug_out); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b required 0", in_ready); end
        if (debug_out_last !== 1'b0) begin n_fail++; $display("FAIL mid_rst_last: got %b required 0", debug_out_last); end
        foreach (cap_q[i]) if (cap_q[i][16]) n_last++;
        n_checks++;
        if (n_last != 0) begin n_fail++; $display("FAIL mid_no_last: got %0d last flits required 0", n_last); end
        src_q.delete();
        take_word = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL mid_err_clear: got %b required 0", err); end
        cap_q.delete();
        push_word(FT_SINGLE, 32'h0BAD_F00D);
        exp_hdr(16'h000C, 16'h3000, 32'h0000_0000);
        exp_arg(32'h0BAD_F00D, 1'b1);
        timestamp = 32'h0000_0000;
        run_until(HDR_FLITS + 2, 30, "after_reset");
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL post_rst_flit%0d: got %h required %h", i, (i < cap_q.size()) ? cap_q[i] : 17'h0, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_none();
        test_continuation();
        test_random_ready();
        test_protocol_error();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
